// File: rtl/quad_pkg.sv
// Shared constants for the quadrature decoder: mode codes, control FSM states
// and the transition keys {a_deb, a_prev, b_deb, b_prev} the decoder acts on.
package quad_pkg;

  localparam int unsigned MODE_X2 = 0;
  localparam int unsigned MODE_X4 = 1;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PRIME,
    ST_RUN
  } state_e;

  // Counted in both resolutions (x2 detents leave 00 or 11)
  localparam logic [3:0] KEY_UP_0 = 4'b1000;  // 00 -> 10
  localparam logic [3:0] KEY_UP_1 = 4'b0111;  // 11 -> 01
  localparam logic [3:0] KEY_DN_0 = 4'b0010;  // 00 -> 01
  localparam logic [3:0] KEY_DN_1 = 4'b1101;  // 11 -> 10

  // Extra quarter steps counted only at x4 resolution
  localparam logic [3:0] KEY_UP4_0 = 4'b1110;  // 10 -> 11
  localparam logic [3:0] KEY_UP4_1 = 4'b0001;  // 01 -> 00
  localparam logic [3:0] KEY_DN4_0 = 4'b1011;  // 01 -> 11
  localparam logic [3:0] KEY_DN4_1 = 4'b0100;  // 10 -> 00

  // Both channels moved at once: position is unknown
  localparam logic [3:0] KEY_ERR_0 = 4'b1010;
  localparam logic [3:0] KEY_ERR_1 = 4'b0101;
  localparam logic [3:0] KEY_ERR_2 = 4'b1001;
  localparam logic [3:0] KEY_ERR_3 = 4'b0110;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability filter for one encoder channel.
// Until the filter has primed itself (third edge after reset, lining up with the
// decoder's FILL/PRIME window) the synchroniser output is passed straight through,
// so the decoder's previous-state registers capture the real idle level.
module debounce_filter #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic s1_q, s2_q;

  // Synchroniser for the asynchronous raw input
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
    end
  end

  generate
    if (CYCLES == 0) begin : g_bypass
      assign out = s2_q;
    end else begin : g_filt
      localparam int CW = $clog2(CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

      logic [CW-1:0] cnt_q;
      logic          deb_q;
      logic [1:0]    boot_q;

      // Accept a new level only after CYCLES consecutive differing cycles
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q  <= '0;
          deb_q  <= 1'b0;
          boot_q <= '0;
        end else if (boot_q != 2'd3) begin
          boot_q <= boot_q + 2'd1;
          cnt_q  <= '0;
          if (boot_q == 2'd2) deb_q <= s2_q;
        end else if (s2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == LAST) begin
          deb_q <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign out = (boot_q == 2'd3) ? deb_q : s2_q;
    end
  endgenerate

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: debounced a/b, x2/x4 step decode, wrapping or
// saturating position register with synchronous load, step/dir/err strobes.
module quad_decoder import quad_pkg::*; #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned INCREMENT       = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MODE            = MODE_X2,
  parameter bit          SATURATE        = 1'b0,
  parameter int unsigned MAX_VALUE       = (1 << WIDTH) - 1,
  parameter int unsigned INIT            = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam logic [WIDTH:0]   INC_W  = (WIDTH + 1)'(INCREMENT);
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH + 1)'(MAX_VALUE);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  logic             a_deb, b_deb, oa_q, ob_q;
  state_e           state_q;
  logic             fill_q;
  logic [WIDTH-1:0] value_q;
  logic             step_q, dir_q, err_q;
  logic [3:0]       key;
  logic             ev_up, ev_dn, ev_err;
  logic [WIDTH:0]   sum, diff, ld_ext;
  logic [WIDTH-1:0] up_val, dn_val, ld_val;

  debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset(reset), .in(a), .out(a_deb)
  );
  debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset(reset), .in(b), .out(b_deb)
  );

  // Classify the debounced transition; nothing is decoded before RUN
  always_comb begin
    key    = {a_deb, oa_q, b_deb, ob_q};
    ev_up  = 1'b0;
    ev_dn  = 1'b0;
    ev_err = 1'b0;
    if (state_q == ST_RUN) begin
      case (key)
        KEY_UP_0, KEY_UP_1:   ev_up = 1'b1;
        KEY_DN_0, KEY_DN_1:   ev_dn = 1'b1;
        KEY_UP4_0, KEY_UP4_1: ev_up = (MODE == MODE_X4);
        KEY_DN4_0, KEY_DN4_1: ev_dn = (MODE == MODE_X4);
        KEY_ERR_0, KEY_ERR_1, KEY_ERR_2, KEY_ERR_3: ev_err = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-value candidates, one bit wider so carry/borrow are visible
  always_comb begin
    sum    = {1'b0, value_q} + INC_W;
    diff   = {1'b0, value_q} - INC_W;
    ld_ext = {1'b0, load_value};
    up_val = sum[WIDTH-1:0];
    dn_val = diff[WIDTH-1:0];
    ld_val = load_value;
    if (SATURATE) begin
      if (sum > MAX_W)    up_val = MAX_W[WIDTH-1:0];
      if (diff[WIDTH])    dn_val = '0;
      if (ld_ext > MAX_W) ld_val = MAX_W[WIDTH-1:0];
    end
  end

  // Control FSM, previous-state tracking and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      fill_q  <= 1'b0;
      oa_q    <= 1'b0;
      ob_q    <= 1'b0;
      value_q <= INIT_W;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      oa_q   <= a_deb;
      ob_q   <= b_deb;
      step_q <= 1'b0;
      err_q  <= ev_err;
      case (state_q)
        ST_FILL: begin
          fill_q <= 1'b1;
          if (fill_q) state_q <= ST_PRIME;
        end
        default: state_q <= ST_RUN;
      endcase
      if (load) begin
        value_q <= ld_val;
      end else if (ev_up || ev_dn) begin
        value_q <= ev_up ? up_val : dn_val;
        step_q  <= 1'b1;
        dir_q   <= ev_up;
      end
    end
  end

  assign value = value_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: three configurations side by side, checked against a
// phase-angle model of the encoder (CW order 00->10->11->01 is +1).
module tb_quad_decoder;

  localparam int P_W    [3] = '{8, 4, 4};
  localparam int P_INC  [3] = '{1, 1, 5};
  localparam int P_D    [3] = '{4, 0, 16};
  localparam int P_MODE [3] = '{0, 1, 1};
  localparam int P_SAT  [3] = '{0, 0, 1};
  localparam int P_MAX  [3] = '{255, 15, 12};
  localparam int P_INIT [3] = '{0, 0, 2};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] a = 3'b111, b = 3'b111, ld = 3'b000;
  logic [7:0] lv0 = '0;
  logic [3:0] lv1 = '0, lv2 = '0;
  logic [7:0] v0;
  logic [3:0] v1, v2;
  logic [2:0] stp, dr, er;

  int tests = 0, fails = 0;
  int mval [3], mdir [3];
  int nstep [3] = '{0, 0, 0};
  int nerr  [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(8), .INCREMENT(1), .DEBOUNCE_CYCLES(4), .MODE(0),
                 .SATURATE(1'b0), .MAX_VALUE(255), .INIT(0)) u0 (
    .clk(clk), .reset(reset), .a(a[0]), .b(b[0]), .load(ld[0]), .load_value(lv0),
    .value(v0), .step(stp[0]), .dir(dr[0]), .err(er[0]));
  quad_decoder #(.WIDTH(4), .INCREMENT(1), .DEBOUNCE_CYCLES(0), .MODE(1),
                 .SATURATE(1'b0), .MAX_VALUE(15), .INIT(0)) u1 (
    .clk(clk), .reset(reset), .a(a[1]), .b(b[1]), .load(ld[1]), .load_value(lv1),
    .value(v1), .step(stp[1]), .dir(dr[1]), .err(er[1]));
  quad_decoder #(.WIDTH(4), .INCREMENT(5), .DEBOUNCE_CYCLES(16), .MODE(1),
                 .SATURATE(1'b1), .MAX_VALUE(12), .INIT(2)) u2 (
    .clk(clk), .reset(reset), .a(a[2]), .b(b[2]), .load(ld[2]), .load_value(lv2),
    .value(v2), .step(stp[2]), .dir(dr[2]), .err(er[2]));

  // Pulse monitor: counts cycles each strobe is high
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (stp[i]) nstep[i]++;
      if (er[i])  nerr[i]++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int getv(input int i);
    case (i)
      0:       return int'(v0);
      1:       return int'(v1);
      default: return int'(v2);
    endcase
  endfunction

  function automatic int ph(input logic x, input logic y);
    return x ? (y ? 2 : 1) : (y ? 3 : 0);
  endfunction

  function automatic int step_val(input int i, input bit up);
    int m = 1 << P_W[i];
    int v = up ? mval[i] + P_INC[i] : mval[i] - P_INC[i];
    if (P_SAT[i] != 0) begin
      if (v > P_MAX[i]) v = P_MAX[i];
      if (v < 0) v = 0;
    end else begin
      v = ((v % m) + m) % m;
    end
    return v;
  endfunction

  // Update model for a level change on instance i; report expected pulses
  task automatic model_move(input int i, input logic na, input logic nb,
                            output int es, output int ee);
    int po = ph(a[i], b[i]);
    int d  = (ph(na, nb) - po + 4) % 4;
    es = 0;
    ee = 0;
    if (d == 2) ee = 1;
    else if (d != 0 && (P_MODE[i] == 1 || po % 2 == 0)) begin
      es = 1;
      mval[i] = step_val(i, d == 1);
      mdir[i] = (d == 1) ? 1 : 0;
    end
  endtask

  task automatic move(input int i, input logic na, input logic nb);
    int es, ee, bs, be;
    model_move(i, na, nb, es, ee);
    bs = nstep[i];
    be = nerr[i];
    @(negedge clk);
    a[i] = na;
    b[i] = nb;
    repeat (P_D[i] + 6) @(negedge clk);
    chk($sformatf("u%0d_steps", i), nstep[i] - bs, es);
    chk($sformatf("u%0d_errs", i), nerr[i] - be, ee);
    chk($sformatf("u%0d_value", i), getv(i), mval[i]);
    chk($sformatf("u%0d_dir", i), int'(dr[i]), mdir[i]);
  endtask

  task automatic do_load(input int i, input int v);
    @(negedge clk);
    ld[i] = 1'b1;
    case (i)
      0:       lv0 = 8'(v);
      1:       lv1 = 4'(v);
      default: lv2 = 4'(v);
    endcase
    @(negedge clk);
    ld[i] = 1'b0;
    mval[i] = (P_SAT[i] != 0 && v > P_MAX[i]) ? P_MAX[i] : v;
    chk($sformatf("u%0d_load", i), getv(i), mval[i]);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_rst_value", i), getv(i), P_INIT[i]);
      chk($sformatf("u%0d_rst_sde", i), int'({stp[i], dr[i], er[i]}), 0);
      mval[i] = P_INIT[i];
      mdir[i] = 0;
    end
    reset = 1'b0;
  endtask

  initial begin
    int es, ee, bs, be, lat;
    int bs3 [3], be3 [3];

    // Reset with both channels idling high
    apply_reset(3);
    for (int i = 0; i < 3; i++) begin bs3[i] = nstep[i]; be3[i] = nerr[i]; end
    repeat (30) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_idle_steps", i), nstep[i] - bs3[i], 0);
      chk($sformatf("u%0d_idle_errs", i), nerr[i] - be3[i], 0);
      chk($sformatf("u%0d_idle_value", i), getv(i), P_INIT[i]);
    end

    // One full CW revolution then CCW back: x2 on u0, x4 on u1
    for (int i = 0; i < 2; i++) begin
      move(i, 1'b0, 1'b1); move(i, 1'b0, 1'b0); move(i, 1'b1, 1'b0); move(i, 1'b1, 1'b1);
      chk($sformatf("u%0d_cw_total", i), getv(i), (i == 0) ? 2 : 4);
      move(i, 1'b1, 1'b0); move(i, 1'b0, 1'b0); move(i, 1'b0, 1'b1); move(i, 1'b1, 1'b1);
      chk($sformatf("u%0d_ccw_total", i), getv(i), 0);
    end

    // Latency through 16-cycle filter: step on edge 19 after the change
    model_move(2, 1'b0, 1'b1, es, ee);
    bs = nstep[2];
    @(negedge clk);
    a[2] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (stp[2]) lat = k;
    end
    chk("u2_latency", lat, 19);
    repeat (3) @(negedge clk);
    chk("u2_lat_steps", nstep[2] - bs, es);
    chk("u2_lat_value", getv(2), mval[2]);

    // 10-cycle glitch on a is discarded
    bs = nstep[2];
    be = nerr[2];
    @(negedge clk);
    a[2] = 1'b1;
    repeat (10) @(negedge clk);
    a[2] = 1'b0;
    repeat (30) @(negedge clk);
    chk("u2_glitch_steps", nstep[2] - bs, 0);
    chk("u2_glitch_errs", nerr[2] - be, 0);
    chk("u2_glitch_value", getv(2), mval[2]);

    // Saturation: 10+5 clamps to 12, 3-5 clamps to 0, load above max clamps
    do_load(2, 10);
    move(2, 1'b0, 1'b0);
    chk("u2_sat_hi", getv(2), 12);
    do_load(2, 3);
    move(2, 1'b0, 1'b1);
    chk("u2_sat_lo", getv(2), 0);
    do_load(2, 15);

    // Wrap: 15 + 1 -> 0 at WIDTH=4
    do_load(1, 15);
    move(1, 1'b0, 1'b1);
    chk("u1_wrap", getv(1), 0);

    // Both channels change together: err only
    move(1, 1'b1, 1'b0);

    // Load lands on the same edge as a decoded step: load wins, no step
    model_move(1, 1'b1, 1'b1, es, ee);
    bs = nstep[1];
    @(negedge clk);
    b[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ld[1] = 1'b1;
    lv1 = 4'd7;
    @(negedge clk);
    ld[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("u1_ldstep_steps", nstep[1] - bs, 0);
    chk("u1_ldstep_value", getv(1), 7);
    chk("u1_ldstep_dir", int'(dr[1]), mdir[1]);

    // Reset midway through a debounce count on u2
    @(negedge clk);
    b[2] = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin bs3[i] = nstep[i]; be3[i] = nerr[i]; end
    apply_reset(2);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_abort_steps", i), nstep[i] - bs3[i], 0);
      chk($sformatf("u%0d_abort_errs", i), nerr[i] - be3[i], 0);
      chk($sformatf("u%0d_abort_value", i), getv(i), P_INIT[i]);
    end

    // Random walk with occasional loads
    for (int r = 0; r < 60; r++) begin
      int i = int'($urandom_range(2, 0));
      if ($urandom_range(5, 0) == 0)
        do_load(i, int'($urandom_range((1 << P_W[i]) - 1, 0)));
      else
        move(i, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
